// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for a shared registered PASS_A/PASS_B/ADD/SUB datapath.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_in_data,
    output logic             dp_sel,
    output logic             dp_add,
    output logic             dp_sub,
    input  logic [WIDTH:0]   dp_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_data,
    input  logic             rsp_ready,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Requesters hold valid and operands until ready; the response holds
    // rsp_valid, rsp_data and rsp_id until rsp_ready.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH:0]   rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic grant_id;
    logic accept;
    logic issue;

    // Ready is gated by RST so no accept strobe is visible while in reset.
    assign accept = (state_q == IDLE) && RST && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;

    assign grant_id = req0_valid ? (req1_valid ? ~last_q : 1'b0) : 1'b1;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_id = ~req0_valid;
`endif

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    id_d    = grant_id;
                    op_d    = grant_id ? req1_op : req0_op;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // The datapath result is only valid in this one cycle.
                rsp_data_d = dp_result;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign issue      = (state_q == ISSUE);
    assign dp_a       = issue ? a_q : '0;
    assign dp_b       = issue ? b_q : '0;
    assign dp_in_data = issue && (op_q == 2'b00);
    assign dp_sel     = issue && (op_q == 2'b01);
    assign dp_add     = issue && (op_q == 2'b10);
    assign dp_sub     = issue && (op_q == 2'b11);

    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign dbg_state_o = state_q;

endmodule
